// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared types for the filter sequencer
package filter_pkg;

    typedef enum logic [1:0] {
        COLOUR     = 2'd0,
        BLUR       = 2'd1,
        BRIGHTNESS = 2'd2,
        EDGES      = 2'd3
    } filter_t;

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        IN_FRAME = 2'd1,
        GAP      = 2'd2
    } seq_state_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - pushbutton synchroniser, debouncer and press edge detector
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        // Any return to the stable level restarts the hold count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/filter_sequencer.sv
// rtl/filter_sequencer.sv - frame-aligned filter/frequency selection control
module filter_sequencer
    import filter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int AUTO_FRAMES     = 120,
    parameter int FC_WIDTH        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_next,
    input  logic                auto_en,
    input  logic [1:0]          freq_flag_in,
    input  logic                sop,
    input  logic                eop,
    input  logic                valid,
    input  logic                ready,
    output logic [1:0]          filter_num,
    output logic [1:0]          freq_flag,
    output logic [FC_WIDTH-1:0] frame_count,
    output logic                switch_pulse
);
    localparam int AW = $clog2(AUTO_FRAMES + 1);

    seq_state_t          state_q, state_d;
    logic [1:0]          pend_num_q, pend_num_d;
    logic [1:0]          pend_flag_q, pend_flag_d;
    logic [AW-1:0]       auto_cnt_q, auto_cnt_d;
    logic [1:0]          filter_num_q, filter_num_d;
    logic [1:0]          freq_flag_q, freq_flag_d;
    logic [FC_WIDTH-1:0] frame_count_q, frame_count_d;
    logic                switch_pulse_q, switch_pulse_d;

    logic press, beat, sop_beat, eop_beat, auto_tick, commit;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_next),
        .press   (press)
    );

    always_comb begin
        beat     = valid & ready;
        sop_beat = beat & sop;
        eop_beat = beat & eop;

        auto_tick  = 1'b0;
        auto_cnt_d = auto_cnt_q;
        if (!auto_en) begin
            auto_cnt_d = '0;
        end else if (eop_beat) begin
            if (auto_cnt_q == AW'(AUTO_FRAMES - 1)) begin
                auto_tick  = 1'b1;
                auto_cnt_d = '0;
            end else begin
                auto_cnt_d = auto_cnt_q + AW'(1);
            end
        end

        pend_num_d  = pend_num_q + {1'b0, press} + {1'b0, auto_tick};
        pend_flag_d = freq_flag_in;

        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            WAIT_SOP: if (sop_beat) state_d = eop ? GAP : IN_FRAME;
            IN_FRAME: if (eop_beat) begin
                state_d = GAP;
                commit  = 1'b1;
            end
            GAP: begin
                // An idle bus between frames is a safe point to apply late changes.
                if (sop_beat) begin
                    if (eop) commit  = 1'b1;
                    else     state_d = IN_FRAME;
                end else if (!valid) begin
                    commit = 1'b1;
                end
            end
            default: state_d = WAIT_SOP;
        endcase

        filter_num_d   = commit ? pend_num_q  : filter_num_q;
        freq_flag_d    = commit ? pend_flag_q : freq_flag_q;
        switch_pulse_d = commit && ((pend_num_q != filter_num_q) || (pend_flag_q != freq_flag_q));
        frame_count_d  = frame_count_q;
        if (eop_beat && (state_q != WAIT_SOP)) frame_count_d = frame_count_q + FC_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= WAIT_SOP;
            pend_num_q     <= '0;
            pend_flag_q    <= '0;
            auto_cnt_q     <= '0;
            filter_num_q   <= '0;
            freq_flag_q    <= '0;
            frame_count_q  <= '0;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_num_q     <= pend_num_d;
            pend_flag_q    <= pend_flag_d;
            auto_cnt_q     <= auto_cnt_d;
            filter_num_q   <= filter_num_d;
            freq_flag_q    <= freq_flag_d;
            frame_count_q  <= frame_count_d;
            switch_pulse_q <= switch_pulse_d;
        end
    end

    assign filter_num   = filter_num_q;
    assign freq_flag    = freq_flag_q;
    assign frame_count  = frame_count_q;
    assign switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_filter_sequencer.sv
// tb/tb_filter_sequencer.sv - self-checking bench for filter_sequencer
module tb_filter_sequencer;
    localparam int FCW = 8;

    logic           clk = 1'b0;
    logic           reset, btn_next, auto_en, sop, eop, valid, ready;
    logic [1:0]     freq_flag_in;
    logic [1:0]     filter_num, freq_flag;
    logic [FCW-1:0] frame_count;
    logic           switch_pulse;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int exp_fc = 0;
    bit synced = 0;

    typedef struct {
        int         np;
        logic [1:0] fin;
        logic       aen;
        logic [1:0] en;
        logic [1:0] ef;
        int         ep;
    } vec_t;

    typedef struct {
        logic [1:0] num;
        logic [1:0] flag;
        int         pulses;
        int         fc;
    } exp_t;

    vec_t vt[10];
    exp_t sb[$];

    filter_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .AUTO_FRAMES     (2),
        .FC_WIDTH        (FCW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_next     (btn_next),
        .auto_en      (auto_en),
        .freq_flag_in (freq_flag_in),
        .sop          (sop),
        .eop          (eop),
        .valid        (valid),
        .ready        (ready),
        .filter_num   (filter_num),
        .freq_flag    (freq_flag),
        .frame_count  (frame_count),
        .switch_pulse (switch_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (switch_pulse) pulse_cnt++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic s, input logic e);
        valid = 1'b1; ready = 1'b1; sop = s; eop = e;
        if (e && synced) exp_fc++;
        if (s) synced = 1'b1;
        tick();
        valid = 1'b0; ready = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic press();
        btn_next = 1'b1;
        repeat (10) tick();
        btn_next = 1'b0;
        repeat (10) tick();
    endtask

    task automatic frame(input int np);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        repeat (np) press();
        repeat (5) beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
    endtask

    initial begin
        int   base;
        exp_t got;

        //            np fin aen  en  ef  ep
        vt[0] = '{3, 2'd0, 1'b0, 2'd0, 2'd0, 1};
        vt[1] = '{3, 2'd0, 1'b0, 2'd3, 2'd0, 1};
        vt[2] = '{2, 2'd0, 1'b0, 2'd1, 2'd0, 1};
        vt[3] = '{0, 2'd2, 1'b0, 2'd1, 2'd2, 1};
        vt[4] = '{0, 2'd2, 1'b0, 2'd1, 2'd2, 0};
        vt[5] = '{1, 2'd1, 1'b0, 2'd2, 2'd1, 1};
        vt[6] = '{2, 2'd0, 1'b0, 2'd0, 2'd0, 1};
        vt[7] = '{0, 2'd0, 1'b1, 2'd0, 2'd0, 0};
        vt[8] = '{0, 2'd0, 1'b1, 2'd1, 2'd0, 1};
        vt[9] = '{0, 2'd0, 1'b1, 2'd1, 2'd0, 0};

        reset = 1'b0; btn_next = 1'b0; auto_en = 1'b0; freq_flag_in = 2'd0;
        sop = 1'b0; eop = 1'b0; valid = 1'b0; ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        chk("reset_filter_num", filter_num, 0);
        chk("reset_freq_flag", freq_flag, 0);
        chk("reset_frame_count", frame_count, 0);
        chk("reset_switch_pulse", switch_pulse, 0);
        beat(1'b0, 1'b1);
        tick();
        chk("eop_before_sop_count", frame_count, 0);

        // Press in beat 3 of the first frame.
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        press();
        repeat (4) beat(1'b0, 1'b0);
        chk("midframe_hold", filter_num, 0);
        beat(1'b0, 1'b1);
        chk("midframe_commit", filter_num, 1);
        chk("midframe_pulse", switch_pulse, 1);
        chk("midframe_count", frame_count, exp_fc);
        tick();
        chk("midframe_pulse_one", switch_pulse, 0);
        repeat (3) tick();

        for (int i = 0; i < 10; i++) begin
            freq_flag_in = vt[i].fin;
            auto_en = vt[i].aen;
            base = pulse_cnt;
            frame(vt[i].np);
            sb.push_back('{vt[i].en, vt[i].ef, vt[i].ep, exp_fc});
            repeat (4) tick();
            got = sb.pop_front();
            chk($sformatf("row%0d_filter_num", i), filter_num, got.num);
            chk($sformatf("row%0d_freq_flag", i), freq_flag, got.flag);
            chk($sformatf("row%0d_pulses", i), pulse_cnt - base, got.pulses);
            chk($sformatf("row%0d_frame_count", i), frame_count, got.fc);
        end

        // Press pulse lands on the same cycle as the frame-4 auto tick.
        base = pulse_cnt;
        beat(1'b1, 1'b0);
        repeat (6) beat(1'b0, 1'b0);
        btn_next = 1'b1;
        repeat (6) tick();
        beat(1'b0, 1'b1);
        repeat (4) tick();
        btn_next = 1'b0;
        repeat (10) tick();
        chk("auto_press_filter", filter_num, 3);
        chk("auto_press_pulses", pulse_cnt - base, 1);
        auto_en = 1'b0;

        // GAP with valid low: commit one cycle after pend_num moves.
        btn_next = 1'b1;
        repeat (6) tick();
        tick();
        chk("gap_idle_before", filter_num, 3);
        tick();
        chk("gap_idle_after", filter_num, 0);
        chk("gap_idle_pulse", switch_pulse, 1);
        tick();
        chk("gap_idle_pulse_one", switch_pulse, 0);
        btn_next = 1'b0;
        repeat (10) tick();

        base = pulse_cnt;
        btn_next = 1'b1;
        repeat (3) tick();
        btn_next = 1'b0;
        repeat (8) tick();
        chk("bounce_reject_filter", filter_num, 0);
        chk("bounce_reject_pulses", pulse_cnt - base, 0);
        press();
        chk("bounce_accept_filter", filter_num, 1);
        chk("bounce_accept_pulses", pulse_cnt - base, 1);

        // GAP with the bus stalled: hold until the next frame ends.
        base = pulse_cnt;
        valid = 1'b1; ready = 1'b0;
        press();
        chk("gap_stall_hold", filter_num, 1);
        chk("gap_stall_pulses", pulse_cnt - base, 0);
        beat(1'b1, 1'b0);
        chk("gap_stall_sop_hold", filter_num, 1);
        repeat (6) beat(1'b0, 1'b0);
        chk("gap_stall_frame_hold", filter_num, 1);
        beat(1'b0, 1'b1);
        chk("gap_stall_commit", filter_num, 2);
        chk("gap_stall_pulse", switch_pulse, 1);
        chk("gap_stall_count", frame_count, exp_fc);
        repeat (4) tick();

        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        synced = 1'b0;
        exp_fc = 0;
        chk("midreset_filter_num", filter_num, 0);
        chk("midreset_freq_flag", freq_flag, 0);
        chk("midreset_frame_count", frame_count, 0);
        chk("midreset_switch_pulse", switch_pulse, 0);
        beat(1'b0, 1'b1);
        tick();
        chk("midreset_eop_ignored", frame_count, exp_fc);
        frame(0);
        repeat (4) tick();
        chk("midreset_next_frame_count", frame_count, exp_fc);
        chk("midreset_next_frame_filter", filter_num, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
